// File: rtl/slave_memory_burst_pkg.sv
// ============================================================================
// Module   : slave_memory_burst_pkg
// Purpose  : Shared types and constants for the burst slave memory: FSM state
//            encoding, legal read-latency range and output FIFO depth
//            derivation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slave_memory_burst_pkg;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Out-of-range latencies are pulled into the supported window.
  function automatic int clamp_latency(input int lat);
    if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
    if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
    return lat;
  endfunction

  // One slot per pipeline stage plus one.  This keeps back-to-back
  // streaming possible while rready is held high.
  function automatic int fifo_depth(input int lat);
    return lat + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slave_mem_rd_fifo.sv
// ============================================================================
// Module   : slave_mem_rd_fifo
// Purpose  : Synchronous FIFO that holds returned read beats {data, last, err}.
//            The depth does not need to be a power of two.
// Ports    : clk, rstn          clock, async active-low reset
//            push, push_data    write side
//            pop, pop_data      read side (pop_data shows the head entry)
//            count, empty       occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_mem_rd_fifo #(
  parameter int DEPTH     = 2,
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     pop_data,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_full;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_full    = (r_count == CNT_WIDTH'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!w_full || w_pop_ok);
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_WIDTH'(1);
        2'b01:   r_count <= r_count - CNT_WIDTH'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/slave_memory_burst.sv
// ============================================================================
// Module   : slave_memory_burst
// Purpose  : Byte-strobed word memory with single-beat writes and
//            incrementing read bursts.  Reads pass through a READ_LATENCY-deep
//            pipeline into an output FIFO.  The FIFO supports rvalid/rready
//            backpressure.  Issue is credit-limited, so the FIFO never
//            overflows.  Memory contents are not reset; all control state is.
// Config   : `define SLAVE_MEM_PARITY_EN adds one even-parity bit per byte.
//            A mismatch on a read flags rerr for that beat.  When the macro is
//            undefined, rerr is tied to 0.
// Ports    : clk, rstn                       clock, async active-low reset
//            req_valid/req_ready             request handshake
//            req_wen, req_addr, req_len      op, start word address, beats-1
//            req_wdata, req_wstrb            write data and byte enables
//            rvalid/rready                   read data handshake
//            rdata, rlast, rerr              read beat, final beat, parity error
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slave_memory_burst
  import slave_memory_burst_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 1,
  parameter int LEN_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rlast,
  output logic                    rerr
);

  localparam int c_strb_w     = DATA_WIDTH / 8;
  localparam int c_maw        = $clog2(MEM_SIZE);
  localparam int c_lat        = clamp_latency(READ_LATENCY);
  localparam int c_fifo_depth = fifo_depth(c_lat);
  localparam int c_cnt_w      = $clog2(c_fifo_depth + 1);
  localparam int c_occ_w      = c_cnt_w + 1;
  localparam int c_entry_w    = DATA_WIDTH + 2;

  state_t               r_state, w_state_nxt;
  logic [c_maw-1:0]     r_addr, w_addr_nxt;
  logic [LEN_WIDTH-1:0] r_beat, w_beat_nxt;
  logic [LEN_WIDTH-1:0] r_len, w_len_nxt;

  logic [c_maw-1:0]      w_req_word;
  logic                  w_issue;
  logic [c_maw-1:0]      w_issue_addr;
  logic                  w_issue_last;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_err;

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  // Read pipeline: stage 0 captures the array at the issue edge.
  logic [c_lat-1:0]      r_sr_vld;
  logic [c_lat-1:0]      r_sr_last;
  logic [c_lat-1:0]      r_sr_err;
  logic [DATA_WIDTH-1:0] r_sr_data [c_lat];

  logic [c_cnt_w-1:0]   w_inflight;
  logic [c_cnt_w-1:0]   w_fifo_count;
  logic                 w_fifo_empty;
  logic [c_entry_w-1:0] w_head;
  logic                 w_pop;
  logic [c_occ_w-1:0]   w_occ;
  logic                 w_has_credit;

  assign w_req_word = req_addr[c_maw-1:0];
  assign w_pop      = rvalid && rready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < c_lat; i++) begin
      w_inflight = w_inflight + c_cnt_w'(r_sr_vld[i]);
    end
  end

  // Occupancy after this edge excludes a beat popped at this edge.  As a
  // result, a slot freed by the pop can take a newly issued beat in the
  // same cycle.
  assign w_occ        = c_occ_w'(w_inflight) + c_occ_w'(w_fifo_count) - c_occ_w'(w_pop);
  assign w_has_credit = (w_occ < c_occ_w'(c_fifo_depth));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_beat_nxt   = r_beat;
    w_len_nxt    = r_len;
    w_issue      = 1'b0;
    w_issue_addr = r_addr;
    w_issue_last = 1'b0;
    w_wr_en      = 1'b0;
    req_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = w_has_credit && rstn;
        if (req_valid && req_ready) begin
          if (req_wen) begin
            w_wr_en = 1'b1;
          end else begin
            w_issue      = 1'b1;
            w_issue_addr = w_req_word;
            w_issue_last = (req_len == '0);
            w_addr_nxt   = w_req_word + c_maw'(1);
            w_beat_nxt   = LEN_WIDTH'(1);
            w_len_nxt    = req_len;
            if (req_len != '0) w_state_nxt = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (w_has_credit) begin
          w_issue      = 1'b1;
          w_issue_last = (r_beat == r_len);
          // Address wraps naturally at MEM_SIZE because the width is log2(MEM_SIZE).
          w_addr_nxt   = r_addr + c_maw'(1);
          w_beat_nxt   = r_beat + LEN_WIDTH'(1);
          if (r_beat == r_len) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_beat  <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_beat  <= w_beat_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // ---------------------------------------------------------------- memory
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (req_wstrb[b]) r_mem[w_req_word][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign w_rd_data = r_mem[w_issue_addr];

`ifdef SLAVE_MEM_PARITY_EN
  logic [c_strb_w-1:0] r_par [MEM_SIZE];
  logic [c_strb_w-1:0] w_rd_par;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < c_strb_w; b++) begin
        if (req_wstrb[b]) r_par[w_req_word][b] <= ^req_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rd_par = '0;
    for (int b = 0; b < c_strb_w; b++) begin
      w_rd_par[b] = ^w_rd_data[8*b +: 8];
    end
  end

  assign w_rd_err = |(w_rd_par ^ r_par[w_issue_addr]);
`else
  assign w_rd_err = 1'b0;
`endif

  // ---------------------------------------------------------------- read pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr_vld  <= '0;
      r_sr_last <= '0;
      r_sr_err  <= '0;
      for (int i = 0; i < c_lat; i++) r_sr_data[i] <= '0;
    end else begin
      r_sr_vld[0]  <= w_issue;
      r_sr_last[0] <= w_issue_last;
      r_sr_err[0]  <= w_rd_err;
      r_sr_data[0] <= w_rd_data;
      for (int i = 1; i < c_lat; i++) begin
        r_sr_vld[i]  <= r_sr_vld[i-1];
        r_sr_last[i] <= r_sr_last[i-1];
        r_sr_err[i]  <= r_sr_err[i-1];
        r_sr_data[i] <= r_sr_data[i-1];
      end
    end
  end

  slave_mem_rd_fifo #(
    .DEPTH     (c_fifo_depth),
    .WIDTH     (c_entry_w),
    .CNT_WIDTH (c_cnt_w)
  ) u_rd_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (r_sr_vld[c_lat-1]),
    .push_data ({r_sr_data[c_lat-1], r_sr_last[c_lat-1], r_sr_err[c_lat-1]}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty)
  );

  assign rvalid = !w_fifo_empty;
  assign rdata  = w_fifo_empty ? '0   : w_head[c_entry_w-1:2];
  assign rlast  = w_fifo_empty ? 1'b0 : w_head[1];
  assign rerr   = w_fifo_empty ? 1'b0 : w_head[0];

endmodule

`default_nettype wire

// File: tb/tb_slave_memory_burst.sv
// ============================================================================
// Module   : tb_slave_memory_burst
// Purpose  : Self-checking bench for slave_memory_burst.
//            - Requests are issued, and an array model of the memory expands
//              each read into its expected beats on a queue.
//            - A separate monitor pops the queue on every rvalid && rready.
//            - The monitor also checks that held beats stay stable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slave_memory_burst;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MS = 256;
  localparam int RL = 3;
  localparam int LW = 4;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          rerr;

  always #5 clk = ~clk;

  slave_memory_burst #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_SIZE     (MS),
    .READ_LATENCY (RL),
    .LEN_WIDTH    (LW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rlast     (rlast),
    .rerr      (rerr)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [MS];
  beat_t         exp_q [$];
  int            rready_mode = 0;  // 0: always 1, 1: random, 2: toggle, 3: always 0

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // rready driver: changes only on the falling edge
  initial forever begin
    @(negedge clk);
    case (rready_mode)
      0:       rready = 1'b1;
      1:       rready = 1'($urandom_range(0, 1));
      2:       rready = ~rready;
      default: rready = 1'b0;
    endcase
  end

  // Monitor: samples once per cycle, after all falling-edge drivers settle
  initial begin
    logic  hold;
    logic [DW-1:0] hd;
    logic  hl;
    beat_t e;
    hold = 1'b0;
    hd   = '0;
    hl   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        hold = 1'b0;
        continue;
      end
      if (hold) begin
        check("hold_rvalid", 64'(rvalid), 64'd1);
        check("hold_rdata", 64'(rdata), 64'(hd));
        check("hold_rlast", 64'(rlast), 64'(hl));
      end
      hold = rvalid && !rready;
      hd   = rdata;
      hl   = rlast;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got rdata 0x%0h with no beat expected at %0t", rdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("rdata", 64'(rdata), 64'(e.data));
          check("rlast", 64'(rlast), 64'(e.last));
          check("rerr", 64'(rerr), 64'd0);
        end
      end
    end
  end

  // Apply the model's effect of an accepted request.
  task automatic model_accept(input logic wen, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                              input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    int    a;
    beat_t b;
    a = int'(addr) % MS;
    if (wen) begin
      for (int k = 0; k < SW; k++) begin
        if (ws[k]) ref_mem[a][8*k +: 8] = wd[8*k +: 8];
      end
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        b.data = ref_mem[(a + i) % MS];
        b.last = (i == int'(len));
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic do_req(input logic wen, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                        input logic [DW-1:0] wd, input logic [SW-1:0] ws);
    bit done;
    done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    req_wstrb = ws;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (req_ready) begin
        done = 1'b1;
        model_accept(wen, addr, len, wd, ws);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: got no req_ready, required acceptance within 300 cycles");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Single-beat read from an idle, empty pipeline: rvalid must rise exactly RL
  // cycles after the accept edge.
  task automatic latency_read(input logic [AW-1:0] addr);
    rready_mode = 0;
    drain();
    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b0;
    req_addr  = addr;
    req_len   = '0;
    #1;
    check("lat_req_ready", 64'(req_ready), 64'd1);
    if (req_ready) model_accept(1'b0, addr, '0, '0, '0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("lat_rvalid_c0", 64'(rvalid), 64'd0);
    for (int i = 1; i <= RL; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_rvalid_c%0d", i), 64'(rvalid), 64'(i == RL));
    end
    drain();
  endtask

  initial begin
    // ---- reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rerr", 64'(rerr), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // ---- fill the whole memory so every later read has a known value
    for (int a = 0; a < MS; a++) do_req(1'b1, AW'(a), '0, DW'($urandom), '1);

    // ---- byte write of 0xA5 to 0x010 (lane 0 only), then read with latency timing
    do_req(1'b1, 12'h010, '0, 32'h0000_00A5, 4'b0001);
    latency_read(12'h010);

    // ---- partial strobe merge
    do_req(1'b1, 12'h030, '0, 32'h1122_3344, 4'b1111);
    do_req(1'b1, 12'h030, '0, 32'hFFFF_FFFF, 4'b0101);
    do_req(1'b0, 12'h030, '0, '0, '0);
    drain();
    check("strobe_merge_model", 64'(ref_mem[8'h30]), 64'h11FF_33FF);

    // ---- burst wrapping past the top of memory (upper address bits set, ignored)
    do_req(1'b0, 12'hF00 | AW'(MS - 2), 4'd3, '0, '0);
    drain();

    // ---- len=7 burst with rready toggling every cycle
    rready_mode = 2;
    do_req(1'b0, 12'h040, 4'd7, '0, '0);
    drain();

    // ---- read-after-write on the same address
    rready_mode = 0;
    do_req(1'b1, 12'h055, '0, 32'hCAFE_F00D, 4'b1111);
    do_req(1'b0, 12'h055, '0, '0, '0);

    // ---- randomized traffic under different backpressure patterns
    for (int p = 0; p < 4; p++) begin
      rready_mode = p % 3;
      for (int n = 0; n < 60; n++) begin
        do_req(1'($urandom_range(0, 2) == 0), AW'($urandom), LW'($urandom),
               DW'($urandom), SW'($urandom));
      end
    end
    rready_mode = 0;
    drain();

    // ---- reset in the middle of a backpressured burst
    rready_mode = 3;
    do_req(1'b0, 12'h080, 4'd15, '0, '0);
    repeat (6) @(negedge clk);
    check("pre_reset_rvalid", 64'(rvalid), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rdata", 64'(rdata), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rready_mode = 0;
    do_req(1'b0, 12'h080, 4'd15, '0, '0);
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue has %0d beats", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
